// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, default
// geometry and the NOP encoding used to blank the instruction store.
package prog_loader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH      = 16;
  localparam logic [7:0] NOP = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_RUN
  } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Upstream byte stream carrying the program image into the loader.
interface prog_loader_if #(
  parameter int DATA_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/prog_mem.sv
// Instruction store: flop array with single-cycle clear-all, one write port
// and a zero-latency read port for the core fetch path.
module prog_mem
  import prog_loader_pkg::*;
#(
  parameter int WORDS  = DEPTH,
  parameter int DATA_W = DATA_W_DEF,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP);

  logic [DATA_W-1:0] mem_q [WORDS];

  // Clear wins over write so a reload never keeps a stale byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: NOP_W};
    end else if (clr_i) begin
      mem_q <= '{default: NOP_W};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Loads a program image from a byte stream into the instruction store, then
// pulses start and serves zero-latency fetches while the core runs.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  prog_loader_if.slave      up,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              start,
  output logic              loaded,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              loaded_q, loaded_d;
  logic              err_q, err_d;
  logic              mem_clr;
  logic              mem_we;
  logic              xfer;
  logic [DATA_W-1:0] rd_data;

  prog_mem #(
    .WORDS  (2 ** ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (mem_clr),
    .we_i    (mem_we),
    .waddr_i (wptr_q),
    .wdata_i (up.in_data),
    .raddr_i (fetch_addr),
    .rdata_o (rd_data)
  );

  assign up.in_ready = (state_q == ST_LOAD);
  assign xfer        = up.in_ready && up.in_valid;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    mem_clr  = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_req) begin
          state_d  = ST_LOAD;
          wptr_d   = '0;
          count_d  = '0;
          loaded_d = 1'b0;
          err_d    = 1'b0;
          mem_clr  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          mem_we  = 1'b1;
          count_d = count_q + 1'b1;
          // The pointer holds at the top word: a full store ends the load
          // rather than wrapping over the start of the image.
          if (wptr_q == LAST_ADDR) begin
            state_d = ST_LAUNCH;
            err_d   = !up.in_last;
          end else begin
            wptr_d = wptr_q + 1'b1;
            if (up.in_last) begin
              state_d = ST_LAUNCH;
            end
          end
        end
      end
      ST_LAUNCH: begin
        loaded_d = 1'b1;
        state_d  = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wptr_q   <= '0;
      count_q  <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  // A partially written image must never reach the decoder.
  assign fetch_instr = (state_q == ST_RUN) ? rd_data : DATA_W'(NOP);
  assign start       = (state_q == ST_LAUNCH);
  assign loaded      = loaded_q;
  assign err         = err_q;
  assign count       = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads, overflow, gaps, reset abort, reloads;
// fetch readback is table-driven.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_req;
  logic [3:0] fetch_addr;
  logic [7:0] fetch_instr;
  logic       start;
  logic       loaded;
  logic       err;
  logic [4:0] count;

  prog_loader_if #(.DATA_W(8)) bus ();

  prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_req    (load_req),
    .up          (bus),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .start       (start),
    .loaded      (loaded),
    .err         (err),
    .count       (count)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int start_cnt = 0;
  int base;

  typedef struct {
    int addr;
    int exp;
  } rd_vec_t;

  rd_vec_t tab[$];

  always @(negedge clk) if (start) start_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    else begin
      pass_cnt++;
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h5A;
  endtask

  task automatic add_rd(input int a, input int e);
    rd_vec_t v;
    v.addr = a;
    v.exp  = e;
    tab.push_back(v);
  endtask

  task automatic run_table(input string tag);
    foreach (tab[i]) begin
      fetch_addr = 4'(tab[i].addr);
      #1;
      chk($sformatf("%s rd[%0d]", tag, tab[i].addr), 32'(fetch_instr), tab[i].exp);
    end
    tab.delete();
  endtask

  int t5_bytes[5] = '{'h21, 'h32, 'h43, 'h54, 'h65};
  int t5_gaps[5]  = '{2, 0, 3, 1, 2};

  initial begin
    rst          = 1'b1;
    load_req     = 1'b0;
    fetch_addr   = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    #2;
    chk("rst in_ready", 32'(bus.in_ready), 0);
    chk("rst start", 32'(start), 0);
    chk("rst loaded", 32'(loaded), 0);
    chk("rst err", 32'(err), 0);
    chk("rst count", 32'(count), 0);
    chk("rst fetch", 32'(fetch_instr), 0);
    step();
    step();
    rst = 1'b0;
    step(); step(); step();
    chk("no autoload", 32'(bus.in_ready), 0);

    // Basic three-byte load
    base = start_cnt;
    begin_load();
    chk("t1 ready", 32'(bus.in_ready), 1);
    chk("t1 count0", 32'(count), 0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    fetch_addr = 4'd0;
    #1;
    chk("t1 start", 32'(start), 1);
    chk("t1 launch nop", 32'(fetch_instr), 0);
    chk("t1 count", 32'(count), 3);
    chk("t1 ready off", 32'(bus.in_ready), 0);
    step();
    chk("t1 start end", 32'(start), 0);
    chk("t1 loaded", 32'(loaded), 1);
    chk("t1 err", 32'(err), 0);
    chk("t1 pulses", 32'(start_cnt - base), 1);
    add_rd(0, 'h11); add_rd(1, 'h22); add_rd(2, 'h33);
    for (int a = 3; a < 16; a++) add_rd(a, 0);
    run_table("t1");

    // Reload from RUN; load_req ignored in LOAD and LAUNCH
    base = start_cnt;
    begin_load();
    chk("t2 loaded drop", 32'(loaded), 0);
    chk("t2 ready", 32'(bus.in_ready), 1);
    load_req = 1'b1;
    send_byte(8'hA1, 1'b0);
    load_req = 1'b0;
    chk("t2 count1", 32'(count), 1);
    send_byte(8'hA2, 1'b1);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    chk("t2 launch ignore", 32'(bus.in_ready), 0);
    chk("t2 loaded", 32'(loaded), 1);
    chk("t2 count", 32'(count), 2);
    chk("t2 pulses", 32'(start_cnt - base), 1);
    add_rd(0, 'hA1); add_rd(1, 'hA2); add_rd(2, 0);
    run_table("t2");

    // Overflow: 17 bytes offered, no in_last
    base = start_cnt;
    begin_load();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1'b0);
    chk("t3 start", 32'(start), 1);
    chk("t3 err", 32'(err), 1);
    chk("t3 count", 32'(count), 16);
    chk("t3 ready off", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    step();
    chk("t3 ready stay", 32'(bus.in_ready), 0);
    step();
    step();
    bus.in_valid = 1'b0;
    chk("t3 count hold", 32'(count), 16);
    chk("t3 err hold", 32'(err), 1);
    chk("t3 loaded", 32'(loaded), 1);
    chk("t3 pulses", 32'(start_cnt - base), 1);
    add_rd(0, 'h40); add_rd(7, 'h47); add_rd(15, 'h4F);
    run_table("t3");

    // Full 16 bytes with in_last on the 16th
    base = start_cnt;
    begin_load();
    chk("t4 err clr", 32'(err), 0);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), i == 15);
    chk("t4 err", 32'(err), 0);
    chk("t4 count", 32'(count), 16);
    chk("t4 start", 32'(start), 1);
    step();
    chk("t4 pulses", 32'(start_cnt - base), 1);
    add_rd(0, 'h80); add_rd(15, 'h8F);
    run_table("t4");

    // Five bytes with idle gaps; fetch must read NOP throughout LOAD
    begin_load();
    for (int i = 0; i < 5; i++) begin
      for (int g = 0; g < t5_gaps[i]; g++) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b1;
        bus.in_data  = 8'(8'hF0 + g);
        fetch_addr   = 4'($urandom_range(0, 15));
        #1;
        chk("t5 load nop", 32'(fetch_instr), 0);
        step();
      end
      fetch_addr = 4'(i);
      #1;
      chk("t5 load nop", 32'(fetch_instr), 0);
      send_byte(8'(t5_bytes[i]), i == 4);
    end
    step();
    chk("t5 count", 32'(count), 5);
    for (int i = 0; i < 5; i++) add_rd(i, t5_bytes[i]);
    add_rd(5, 0);
    run_table("t5");

    // Reset mid-load aborts; a fresh load_req is required
    base = start_cnt;
    begin_load();
    send_byte(8'h99, 1'b0);
    send_byte(8'h98, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6 ready", 32'(bus.in_ready), 0);
    chk("t6 count", 32'(count), 0);
    chk("t6 loaded", 32'(loaded), 0);
    chk("t6 err", 32'(err), 0);
    chk("t6 start", 32'(start), 0);
    chk("t6 fetch", 32'(fetch_instr), 0);
    step();
    rst = 1'b0;
    step(); step(); step();
    chk("t6 no reload", 32'(bus.in_ready), 0);
    chk("t6 no pulse", 32'(start_cnt - base), 0);
    begin_load();
    for (int i = 0; i < 30; i++) step();
    chk("t6 wait ready", 32'(bus.in_ready), 1);
    chk("t6 wait count", 32'(count), 0);
    send_byte(8'h77, 1'b1);
    step();
    add_rd(0, 'h77); add_rd(1, 0);
    run_table("t6");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning program address width; it matches the core PC width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning instruction width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port load_req, input, 1 bit: request to begin a new program load.
REQ-006 Port in_valid, input, 1 bit: upstream byte valid.
REQ-007 Port in_ready, output, 1 bit: loader can accept a byte.
REQ-008 Port in_data, input, DATA_W bits: program byte.
REQ-009 Port in_last, input, 1 bit: marks the final byte of the image.
REQ-010 Port fetch_addr, input, ADDR_W bits: core PC.
REQ-011 Port fetch_instr, output, DATA_W bits: instruction to the core decoder.
REQ-012 Port start, output, 1 bit: one-cycle pulse that launches the core.
REQ-013 Port loaded, output, 1 bit: a valid program is resident.
REQ-014 Port err, output, 1 bit: the last load overflowed.
REQ-015 Port count, output, ADDR_W+1 bits: number of bytes written by the last load.

Function
REQ-016 The block SHALL contain 2**ADDR_W (16) words of DATA_W-bit storage.
REQ-017 The block SHALL implement FSM states IDLE, LOAD, LAUNCH and RUN.
REQ-018 IDLE or RUN, with load_req=1: the next state SHALL be LOAD. In the same edge, all words clear to 8'h00 (NOP), the write pointer clears to 0, count clears to 0, and loaded and err clear to 0.
REQ-019 load_req SHALL be ignored in LOAD and LAUNCH.
REQ-020 in_ready SHALL be 1 only in LOAD (registered, not combinational from in_valid).
REQ-021 A transfer occurs when in_valid & in_ready. On a transfer, in_data SHALL be written to mem[wptr], wptr SHALL increment and count SHALL increment, all on that edge.
REQ-022 A transfer with in_last=1 SHALL move the FSM to LAUNCH.
REQ-023 A transfer into word 15 with in_last=0 SHALL move the FSM to LAUNCH and set err=1; later upstream bytes are not accepted.
REQ-024 A transfer into word 15 with in_last=1 SHALL move the FSM to LAUNCH with err=0.
REQ-025 wptr SHALL never wrap within one load.
REQ-026 LAUNCH SHALL assert start=1 for exactly one cycle, set loaded=1, and move to RUN on the next edge.
REQ-027 In RUN, fetch_instr SHALL equal mem[fetch_addr] combinationally (zero latency).
REQ-028 In IDLE, LOAD and LAUNCH, fetch_instr SHALL be forced to 8'h00 so that a partial image is never executed.
REQ-029 Words not written by a load SHALL read as 8'h00.
REQ-030 A load with no transfers SHALL remain in LOAD indefinitely; there is no timeout.

Reset
REQ-031 On rst=1, asynchronously: state=IDLE, wptr=0, count=0, in_ready=0, start=0, loaded=0, err=0, and all memory words=8'h00.
REQ-032 Reset asserted mid-LOAD SHALL abort the load; no start pulse SHALL be issued.
REQ-033 The first load after reset deassertion SHALL require load_req.

Structure
REQ-034 The shared package SHALL hold the FSM state typedef, the ADDR_W and DATA_W defaults, DEPTH=16, and the NOP encoding 8'h00.
REQ-035 Storage SHALL be one sub-module, prog_mem: 16x8 flops with clear-all, one write port and one asynchronous read port.
REQ-036 prog_loader SHALL instantiate prog_mem and hold the FSM, wptr and count.

Verification
REQ-037 Reset, then load_req, then bytes 0x11,0x22,0x33 with in_last on 0x33 -> start pulses once 1 cycle after the last transfer; count=3; fetch_addr 0..2 reads 0x11/0x22/0x33; fetch_addr 3..15 reads 0x00; err=0.
REQ-038 Load of 17 bytes without in_last -> 16 accepted, in_ready=0 after the 16th, err=1, count=16, mem[15]=16th byte, start pulses once.
REQ-039 16 bytes with in_last on the 16th -> err=0, count=16, start pulses once.
REQ-040 Random in_valid gaps during a 5-byte load -> only handshaked bytes are stored, in order; fetch_instr=0x00 throughout LOAD for every fetch_addr.
REQ-041 rst asserted after 2 of 4 bytes -> all outputs at reset values immediately, no start pulse; memory reads 0x00 after the next load with no bytes... a new load_req is required.
REQ-042 load_req pulsed during LOAD and during LAUNCH -> ignored; load_req in RUN -> reload, loaded drops to 0 the next cycle, old image cleared.
